nway_cache: RTL and testbench
=============================

# nway_cache

Parametrised N-way set-associative, write-back, write-allocate cache that generalises the team's fixed 2-way pipeline cache. It sits between a pipeline stage (instruction or data port) and the physical memory arbiter, serving 32-bit word accesses with byte enables from 256-bit lines. It uses tree pseudo-LRU replacement and supports a bulk invalidate. An optional hit/miss counter block is compiled in by macro.

## Interface
- `s_offset`, 5: line offset bits; fixed at 5 for 256-bit lines.
- `s_index`, 3: set index bits; `num_sets` = 2**s_index.
- `num_ways`, 2: associativity; power of two, 2..8.
- `s_tag`, 32-s_offset-s_index: tag width (derived).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: CPU read request.
- `mem_write` in 1: CPU write request; never asserted together with `mem_read`.
- `mem_byte_enable` in 4: write byte lanes.
- `mem_address` in 32: byte address; bits [4:2] select the word.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data, valid while `mem_resp` is high.
- `mem_resp` out 1: request complete.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line writeback request.
- `pmem_address` out 32: line address, low 5 bits zero.
- `pmem_wdata` out 256: victim line data.
- `pmem_rdata` in 256: fill data.
- `pmem_resp` in 1: memory transaction done.
- `cpu_stall` in 1: pipeline frozen by another source.
- `clear` in 1: invalidate all lines.

## Operation
- Storage is flop-based, per way per set: valid, dirty, tag, 256-bit data. Each set has `num_ways`-1 PLRU bits.
- FSM states are IDLE, WRITEBACK, FILL and CLEAR.
- **IDLE**
  - A request has its tag compared combinationally across all ways. At most one way may match; more than one is an assertion failure.
  - **Hit:** `mem_resp`=1 in the same cycle, and `mem_rdata` = the selected word of the hit way.
  - **Write hit:** the enabled bytes merge into the line at the clock edge and dirty is set.
  - **PLRU on hit:** bits are updated to point away from the hit way.
  - **Miss:** the victim is the first invalid way (lowest index), else the PLRU way. Go to WRITEBACK if the victim is valid and dirty, else go to FILL.
- **cpu_stall high in IDLE:** `mem_resp`/`mem_rdata` still reflect the hit. No data, dirty or PLRU update occurs and no miss is started.
- **WRITEBACK:** `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata` = victim line. Held stable until `pmem_resp`, then go to FILL.
- **FILL**
  - `pmem_read`=1, `pmem_address`={req tag, index, 5'b0}, held until `pmem_resp`.
  - On `pmem_resp`: the victim way is loaded with `pmem_rdata`, valid=1, dirty=0, tag written. Then return to IDLE, where the retried request hits.
- The victim way is latched on leaving IDLE. It does not change during a miss.
- **clear:** sampled in IDLE only; it takes priority over a simultaneous request. Go to CLEAR for one cycle: all valid, dirty and PLRU bits go to 0, dirty data is discarded, `mem_resp`=0. Then return to IDLE. A `clear` arriving during a miss is ignored; the requester must hold it.
- The requester holds address, data and controls stable until `mem_resp`.

## Timing
- Reset values:
  - Outputs: `mem_resp`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `mem_rdata`=0.
  - State: FSM=IDLE; all valid, dirty and PLRU bits 0. Tags and data are not reset.
- Hit latency: 0 cycles (combinational response in the request cycle).
- Clean miss: FILL entered 1 cycle after the request. Response = memory latency + 1 cycle in IDLE.
- Dirty miss: writeback latency + fill latency + 1 cycle.
- `pmem_*` outputs are driven from registered state and victim data, with no combinational path from `mem_*`.
- Reset asserted mid-miss aborts the transaction immediately. Outputs go to reset values and the array is invalidated.

## Configuration
- `CACHE_PERF_CNT_EN`
  - **Defined:** adds outputs `hit_count` (out, 32) and `miss_count` (out, 32).
    - `hit_count` increments on every non-stalled IDLE hit cycle that is not the retry after a fill.
    - `miss_count` increments on every miss start.
    - Both saturate at 0xFFFF_FFFF, reset to 0 and are zeroed by `clear`.
  - **Undefined:** the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Package `cache_pkg`:
  - FSM state enum (`cache_state_t`).
  - `line_t` (logic [255:0]).
  - `LINE_BYTES`=32, `WORD_SEL` bit range.
- Sub-module `plru_tree #(num_ways)`, purely combinational:
  - Victim select from the PLRU bits.
  - Next-bits computation for a given touched way.

## Test plan
- **Cold read:** after reset, read 0x0000_0104 → FILL at 0x0000_0100; `pmem_rdata` word 1 = 0xDEAD_BEEF → `mem_rdata`=0xDEAD_BEEF, with `mem_resp` one cycle after `pmem_resp`.
- **Write hit byte merge:** write 0x1122_3344 with BE=4'b0101 over 0xDEAD_BEEF → a subsequent read returns 0xDE22_BE44; no pmem traffic.
- **Dirty eviction:** num_ways=2, fill both ways of set 0, dirty the older way, then miss a third tag → `pmem_write` at the older line address with the merged data, followed by `pmem_read` of the new line.
- **PLRU order:** num_ways=4, fill ways 0–3, hit ways 0, 2, 1 in turn → the next miss evicts way 3.
- **cpu_stall:** a write hit with `cpu_stall`=1 for 3 cycles → `mem_resp`=1 and data unchanged; on stall release the write commits once.
- **clear:** write dirty data, pulse `clear` → the next read of the same address misses with no writeback. With the macro defined, both counters read 0.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared state encoding, line type and word-select range for nway_cache
// Revision : 1.0
// ============================================================================
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2,
    S_CLEAR     = 2'd3
  } cache_state_t;

  typedef logic [255:0] line_t;

  localparam int LINE_BYTES   = 32;
  localparam int WORD_SEL_MSB = 4;
  localparam int WORD_SEL_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/nway_cache_plru.sv
`default_nettype none
// ============================================================================
// Module   : plru_tree
// Brief    : Tree pseudo-LRU victim select and touch update, purely combinational
// Revision : 1.0
// ============================================================================
module plru_tree #(
  parameter int num_ways = 2,
  localparam int WAY_W   = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] bits_i,
  input  logic [WAY_W-1:0]    touch_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic [num_ways-2:0] next_o
);

  // Heap-ordered nodes: node n lives at bit n-1, children are {n,0} and {n,1}.
  // A node bit points at the subtree holding the least recently used way.
  logic [num_ways-1:0] w_bits_pad;
  logic [num_ways-1:0] w_next_pad;
  logic [WAY_W:0]      w_vnode;
  logic [WAY_W:0]      w_tnode;
  logic                w_unused;

  assign w_bits_pad = {1'b0, bits_i};

  always_comb begin
    w_vnode    = {{WAY_W{1'b0}}, 1'b1};
    w_tnode    = {{WAY_W{1'b0}}, 1'b1};
    w_next_pad = w_bits_pad;
    for (int l = 0; l < WAY_W; l++) begin
      w_vnode = {w_vnode[WAY_W-1:0], w_bits_pad[w_vnode[WAY_W-1:0] - WAY_W'(1)]};
      w_next_pad[w_tnode[WAY_W-1:0] - WAY_W'(1)] = ~touch_i[WAY_W-1-l];
      w_tnode = {w_tnode[WAY_W-1:0], touch_i[WAY_W-1-l]};
    end
  end

  assign victim_o = w_vnode[WAY_W-1:0];
  assign next_o   = w_next_pad[num_ways-2:0];
  assign w_unused = ^{w_next_pad[num_ways-1], w_tnode};

endmodule
`default_nettype wire

// File: rtl/nway_cache.sv
`default_nettype none
// ============================================================================
// Module   : nway_cache
// Brief    : N-way set-associative write-back cache, tree PLRU, bulk clear.
//            CACHE_PERF_CNT_EN adds saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
module nway_cache
  import cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 2,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  input  logic         cpu_stall,
  input  logic         clear
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int num_sets = 2**s_index;
  localparam int WAY_W    = $clog2(num_ways);

  cache_state_t          state_q, state_d;
  logic [num_ways-1:0]   valid_q [num_sets];
  logic [num_ways-1:0]   dirty_q [num_sets];
  logic [num_ways-2:0]   plru_q  [num_sets];
  logic [s_tag-1:0]      tag_q   [num_ways][num_sets];
  line_t                 data_q  [num_ways][num_sets];
  logic [WAY_W-1:0]      victim_q;
  logic [31-s_offset:0]  addr_q;

  logic [s_index-1:0]    w_idx, w_q_idx;
  logic [s_tag-1:0]      w_tag, w_q_tag;
  logic [2:0]            w_word;
  logic                  w_req;
  logic [num_ways-1:0]   w_hit;
  logic [WAY_W-1:0]      w_hit_way, w_inv_way, w_victim, w_plru_victim;
  logic [num_ways-2:0]   w_plru_next;
  logic                  w_victim_dirty;
  line_t                 w_hit_line, w_merged;
  logic                  w_upd, w_miss, w_fill;
  logic                  w_unused;

  assign w_idx    = mem_address[s_offset +: s_index];
  assign w_tag    = mem_address[31 -: s_tag];
  assign w_word   = mem_address[WORD_SEL_MSB:WORD_SEL_LSB];
  assign w_q_idx  = addr_q[s_index-1:0];
  assign w_q_tag  = addr_q[31-s_offset -: s_tag];
  assign w_req    = mem_read | mem_write;
  assign w_unused = ^mem_address[1:0];

  always_comb begin
    w_hit     = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[w_idx][w] && (tag_q[w][w_idx] == w_tag)) begin
        w_hit[w]  = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[w_idx][w]) w_inv_way = WAY_W'(w);
    end
    w_victim = (&valid_q[w_idx]) ? w_plru_victim : w_inv_way;
  end

  assign w_victim_dirty = valid_q[w_idx][w_victim] & dirty_q[w_idx][w_victim];
  assign w_hit_line     = data_q[w_hit_way][w_idx];

  always_comb begin
    w_merged = w_hit_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) w_merged[{w_word, 5'd0} + b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  plru_tree #(.num_ways(num_ways)) u_plru (
    .bits_i   (plru_q[w_idx]),
    .touch_i  (w_hit_way),
    .victim_o (w_plru_victim),
    .next_o   (w_plru_next)
  );

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_upd        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
        end else if (w_req) begin
          if (|w_hit) begin
            mem_resp  = 1'b1;
            mem_rdata = w_hit_line[{w_word, 5'd0} +: 32];
            w_upd     = ~cpu_stall;
          end else if (!cpu_stall) begin
            w_miss  = 1'b1;
            state_d = w_victim_dirty ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][w_q_idx], w_q_idx, {s_offset{1'b0}}};
        pmem_wdata   = data_q[victim_q][w_q_idx];
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {w_q_tag, w_q_idx, {s_offset{1'b0}}};
        if (pmem_resp) begin
          w_fill  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      addr_q   <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (w_upd) begin
        plru_q[w_idx] <= w_plru_next;
        if (mem_write) dirty_q[w_idx][w_hit_way] <= 1'b1;
      end
      // Victim and address are frozen here so pmem_* never depends on mem_*.
      if (w_miss) begin
        victim_q <= w_victim;
        addr_q   <= mem_address[31:s_offset];
      end
      if (w_fill) begin
        valid_q[w_q_idx][victim_q] <= 1'b1;
        dirty_q[w_q_idx][victim_q] <= 1'b0;
      end
      if (state_q == S_CLEAR) begin
        for (int s = 0; s < num_sets; s++) begin
          valid_q[s] <= '0;
          dirty_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_upd && mem_write) data_q[w_hit_way][w_idx] <= w_merged;
    if (w_fill) begin
      data_q[victim_q][w_q_idx] <= pmem_rdata;
      tag_q[victim_q][w_q_idx]  <= w_q_tag;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_hit));

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      if (w_fill) retry_q <= 1'b1;
      else if (state_q == S_IDLE && !cpu_stall) retry_q <= 1'b0;
      if (state_q == S_CLEAR) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        if (w_upd && !retry_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        if (w_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nway_cache.sv
`default_nettype none
// Scoreboard bench: a 2-way and a 4-way nway_cache share one requester and one
// memory model; sel picks which instance is active.
module tb_nway_cache;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0, stall = 1'b0, clear = 1'b0;
  logic [3:0]   be = '0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [255:0] prdata = '0;
  logic         presp = 1'b0;

  logic         u0_resp, u1_resp, u0_pread, u1_pread, u0_pwrite, u1_pwrite;
  logic [31:0]  u0_rdata, u1_rdata, u0_paddr, u1_paddr;
  logic [255:0] u0_pwdata, u1_pwdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  u0_hit, u0_miss, u1_hit, u1_miss;
`endif

  logic         resp, p_read, p_write;
  logic [31:0]  rdata, p_addr;
  logic [255:0] p_wdata;
  assign resp    = sel ? u1_resp   : u0_resp;
  assign rdata   = sel ? u1_rdata  : u0_rdata;
  assign p_read  = sel ? u1_pread  : u0_pread;
  assign p_write = sel ? u1_pwrite : u0_pwrite;
  assign p_addr  = sel ? u1_paddr  : u0_paddr;
  assign p_wdata = sel ? u1_pwdata : u0_pwdata;

  nway_cache #(.num_ways(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read & ~sel), .mem_write(mem_write & ~sel),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
    .mem_rdata(u0_rdata), .mem_resp(u0_resp),
    .pmem_read(u0_pread), .pmem_write(u0_pwrite), .pmem_address(u0_paddr),
    .pmem_wdata(u0_pwdata), .pmem_rdata(prdata), .pmem_resp(presp & ~sel),
    .cpu_stall(stall & ~sel), .clear(clear & ~sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(u0_hit), .miss_count(u0_miss)
`endif
  );

  nway_cache #(.num_ways(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read & sel), .mem_write(mem_write & sel),
    .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata),
    .mem_rdata(u1_rdata), .mem_resp(u1_resp),
    .pmem_read(u1_pread), .pmem_write(u1_pwrite), .pmem_address(u1_paddr),
    .pmem_wdata(u1_pwdata), .pmem_rdata(prdata), .pmem_resp(presp & sel),
    .cpu_stall(stall & sel), .clear(clear & sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(u1_hit), .miss_count(u1_miss)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int presp_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct { string name; logic [31:0] rdata; bit chk_lat; } rexp_t;
  typedef struct { string name; bit wr; logic [31:0] addr; logic [255:0] data; } pexp_t;
  rexp_t rq[$];
  pexp_t pq[$];

  task automatic exp_r(input string name, input logic [31:0] d, input bit lat);
    rexp_t e;
    e.name = name; e.rdata = d; e.chk_lat = lat;
    rq.push_back(e);
  endtask

  task automatic exp_p(input string name, input bit wr, input logic [31:0] a, input logic [255:0] d);
    pexp_t e;
    e.name = name; e.wr = wr; e.addr = a; e.data = d;
    pq.push_back(e);
  endtask

  // Memory contents: word i of line A is A+4*i unless written or preloaded.
  logic [255:0] mem [logic [31:0]];

  function automatic logic [255:0] pat_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i*4);
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat_line(a);
  endfunction

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && resp) begin
      if (rq.size() == 0) begin
        check("unexpected_resp", 256'(resp), 256'(0));
      end else begin
        rexp_t e;
        e = rq.pop_front();
        check(e.name, 256'(rdata), 256'(e.rdata));
        if (e.chk_lat) check({e.name, "_lat"}, 256'(cyc - presp_cyc), 256'(1));
      end
    end
  end

  // Memory responder and pmem monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && (p_read || p_write)) begin
      logic [31:0]  a;
      logic         w;
      logic [255:0] d;
      a = p_addr; w = p_write; d = p_wdata;
      if (pq.size() == 0) begin
        check("unexpected_pmem", 256'({p_write, p_read, p_addr}), 256'(0));
      end else begin
        pexp_t e;
        e = pq.pop_front();
        check({e.name, "_wr"}, 256'(w), 256'(e.wr));
        check({e.name, "_addr"}, 256'(a), 256'(e.addr));
        if (e.wr) check({e.name, "_data"}, d, e.data);
      end
      repeat (MEM_LAT) @(posedge clk);
      #1;
      if (w) mem[a] = d;
      else prdata = get_line(a);
      presp = 1'b1;
      presp_cyc = cyc;
      @(posedge clk);
      #1 presp = 1'b0;
    end
  end

  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input string name);
    int n;
    @(posedge clk); #1;
    mem_read = ~wr; mem_write = wr; addr = a; wdata = wd; be = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp && n < 200);
    if (!resp) check({name, "_timeout"}, 256'(resp), 256'(1));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  seq [4];
    l = pat_line(32'h100);
    l[63:32] = 32'hDEAD_BEEF;
    mem[32'h100] = l;

    repeat (2) @(negedge clk);
    check("rst_resp",   256'(u0_resp),   256'(0));
    check("rst_pread",  256'(u0_pread),  256'(0));
    check("rst_pwrite", 256'(u0_pwrite), 256'(0));
    check("rst_paddr",  256'(u0_paddr),  256'(0));
    check("rst_pwdata", u0_pwdata,       256'(0));
    check("rst_rdata",  256'(u0_rdata),  256'(0));
    check("rst_resp4",  256'(u1_resp),   256'(0));
    check("rst_pread4", 256'(u1_pread),  256'(0));
    rst_n = 1'b1;

    // 2-way: cold read, write-hit byte merge, dirty eviction
    exp_p("cold_fill", 1'b0, 32'h100, '0);
    exp_r("cold_rd", 32'hDEAD_BEEF, 1'b1);
    req(1'b0, 32'h104, '0, '0, "cold_rd");
    exp_r("wr_hit", 32'hDEAD_BEEF, 1'b0);
    req(1'b1, 32'h104, 32'h1122_3344, 4'b0101, "wr_hit");
    exp_r("merge_rd", 32'hDE22_BE44, 1'b0);
    req(1'b0, 32'h104, '0, '0, "merge_rd");
    exp_p("fill_way1", 1'b0, 32'h200, '0);
    exp_r("rd_200", 32'h200, 1'b0);
    req(1'b0, 32'h200, '0, '0, "rd_200");
    l = pat_line(32'h100);
    l[63:32] = 32'hDE22_BE44;
    exp_p("evict_wb", 1'b1, 32'h100, l);
    exp_p("evict_fill", 1'b0, 32'h300, '0);
    exp_r("rd_304", 32'h304, 1'b0);
    req(1'b0, 32'h304, '0, '0, "rd_304");

    // 4-way: fill ways 0..3, touch 0,2,1, then a miss must evict way 3 (0x400)
    @(posedge clk); #1 sel = 1'b1;
    seq = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int i = 0; i < 4; i++) begin
      exp_p("plru_fill", 1'b0, seq[i], '0);
      exp_r("plru_fill_rd", seq[i], 1'b0);
      req(1'b0, seq[i], '0, '0, "plru_fill_rd");
    end
    seq = '{32'h100, 32'h300, 32'h200, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_r("plru_hit", seq[i], 1'b0);
      req(1'b0, seq[i], '0, '0, "plru_hit");
    end
    exp_p("plru_miss", 1'b0, 32'h500, '0);
    exp_r("plru_miss_rd", 32'h500, 1'b0);
    req(1'b0, 32'h500, '0, '0, "plru_miss_rd");
    seq = '{32'h100, 32'h200, 32'h300, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_r("plru_keep", seq[i], 1'b0);
      req(1'b0, seq[i], '0, '0, "plru_keep");
    end

    // Write hit held by cpu_stall for 3 cycles, commits on release
    for (int i = 0; i < 4; i++) exp_r("stall_wr", 32'h308, 1'b0);
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h308; wdata = 32'hCAFE_F00D; be = 4'hF; stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    @(posedge clk);
    #1 mem_write = 1'b0;
    exp_r("stall_rd", 32'hCAFE_F00D, 1'b0);
    req(1'b0, 32'h308, '0, '0, "stall_rd");
`ifdef CACHE_PERF_CNT_EN
    check("hit_count", 256'(u1_hit), 256'(8));
    check("miss_count", 256'(u1_miss), 256'(5));
`endif

    // clear discards the dirty line: next read refills without a writeback
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef CACHE_PERF_CNT_EN
    check("clr_hit_count", 256'(u1_hit), 256'(0));
    check("clr_miss_count", 256'(u1_miss), 256'(0));
`endif
    exp_p("clr_fill", 1'b0, 32'h300, '0);
    exp_r("clr_rd", 32'h308, 1'b0);
    req(1'b0, 32'h308, '0, '0, "clr_rd");

    repeat (5) @(posedge clk);
    check("resp_queue_left", 256'(rq.size()), 256'(0));
    check("pmem_queue_left", 256'(pq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
